ecc_enc_pipe: RTL and testbench
===============================

# ecc_enc_pipe

Two-stage pipelined, mode-selectable extended-Hamming (SECDED) encoder with valid/ready handshakes on both sides. It accepts one info word per cycle and emits a systematic codeword `{zero pad, data, parity}` at MAX_CODEWORD_WIDTH. Stage 1 computes the row parities. Stage 2 computes the overall parity and packs the word. Mode and a user tag travel with each word, so mode may change every beat. It sits between the data source and the channel/memory write path, upstream of the matching decoder.

## Interface
- MAX_CODEWORD_WIDTH, 32: output codeword width; must be ≥ the largest enabled mode's n.
- MAX_INFO_WIDTH, 26: input data width; must be ≥ the largest enabled mode's k.
- TAG_WIDTH, 4: width of the sideband tag passed through unchanged (≥1).
- ENABLE_MODE2, 1: 0 removes 32-bit mode logic; mode 2'b10 is then treated as invalid.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  encoder can accept a beat this cycle.
- data_in  in  MAX_INFO_WIDTH  info bits, LSB-aligned; bits above k are ignored.
- mod  in  2  code select: 00 = (8,4), 01 = (16,11), 10 = (32,26), 11 = invalid.
- tag_in  in  TAG_WIDTH  sideband, returned with the codeword.
- out_valid  out  1  codeword valid.
- out_ready  in  1  downstream accepts codeword.
- data_out  out  MAX_CODEWORD_WIDTH  codeword.
- tag_out  out  TAG_WIDTH  tag of this codeword.
- out_err  out  1  this beat had an invalid mode.
- err_cnt  out  8  count of invalid-mode beats, saturating at 255.

## Operation
- Codeword layout: data_out[P-1:0] = parity, data_out[k+P-1:P] = data_in[k-1:0], upper bits 0. (k,P) = (4,4), (11,5), (26,6).
- Parity equations come from the H1/H2/H3 constants in ecc_pkg (rows P-1..0, columns n-1..0). The top row is all ones (overall parity). The low P columns are parity positions.
- Row parities parity[i], i = 0..P-2: XOR of data bits selected by H row i's data columns. Computed in stage 1.
- Overall parity parity[P-1]: XOR of all data bits and parity[P-2:0], so the full codeword has even weight. Computed in stage 2.
- Every valid codeword c satisfies H·c = 0 (mod 2).
- Invalid mode (11, or 10 with ENABLE_MODE2 = 0):
  - The beat is accepted and flows through the pipeline normally.
  - data_out = 0 and out_err = 1.
  - err_cnt increments when that beat is accepted at the input.
- No beat is ever dropped or duplicated; order is preserved.

## Timing
- Handshake:
  - A beat transfers on an edge where valid & ready.
  - valid must not depend on ready.
  - data/mod/tag are held stable while valid & !ready.
- Pipeline registers s1 and s2 each carry {valid, data, mode, tag, partial parity}; s2 drives the outputs.
- Readiness, with bubble collapse (both combinational):
  - s2_adv = !s2_valid | out_ready.
  - in_ready = !s1_valid | s2_adv.
- Latency: a beat accepted at edge N has out_valid = 1 after edge N+1, provided out_ready was high, so it is presented 1 cycle after acceptance.
- Throughput: 1 beat per cycle while out_ready = 1.
- Backpressure: with out_ready low, the encoder absorbs at most 2 beats; then in_ready = 0. Outputs hold steady until the transfer.
- Simultaneous events:
  - If s2 unloads and s1 loads on the same edge, both succeed.
  - Counter increment and saturation happen on the same edge.
- Reset (asynchronous, active-high):
  - All valids, data_out, tag_out, out_err and err_cnt go to 0 immediately.
  - in_valid is ignored while rst = 1.
  - In-flight beats are lost.
  - in_ready = 1 in the first cycle after release.

## Structure
- ecc_pkg holds:
  - H1/H2/H3 constants.
  - The (k,P,n) per-mode localparams.
  - A mode enum (MODE_8, MODE_16, MODE_32, MODE_INV).
  - A reference function ecc_encode(mode, data) shared by the RTL bench model.
- One sub-module: ecc_parity_rows, a combinational H-row × data product that returns the P-1 row parities for the selected mode. It is instantiated once in stage 1.
- Top level: handshake control, s1/s2 registers, overall parity, output packing, err_cnt.

## Test plan
- Mode 00, data_in 4'h1, out_ready = 1 → data_out 32'h0000_001B one cycle after acceptance.
- Mode 00, data_in 4'hF → data_out 32'h0000_00FF; mode 10, data_in 0 → data_out 0.
- Back-to-back stream alternating modes 00/01/10, 200 random beats → every codeword matches ecc_encode, has H·c = 0 and even weight, and tags are in order.
- out_ready held low for 5 cycles mid-stream → in_ready falls after 2 absorbed beats, data_out stays stable, no loss or duplication on resume.
- Mode 11 beat with tag 4'hA → data_out 0, out_err 1, tag_out 4'hA, err_cnt +1; 300 invalid beats → err_cnt saturates at 255.
- Assert rst asynchronously with 2 beats in flight → out_valid and err_cnt go to 0 without a clock edge, and the next beat after release encodes correctly.

Source files
------------

// File: rtl/ecc_pkg.sv
// ecc_pkg: SECDED code constants, mode enum and reference encoder shared by the encoder and its bench
// Contents: per-mode (k,P,n), H1/H2/H3 parity-check matrices (rows P-1..0, columns n-1..0),
//           mode_e, ecc_encode(mode, data) returning the systematic codeword {0, data, parity}.
package ecc_pkg;

    typedef enum logic [1:0] {
        MODE_8   = 2'b00,
        MODE_16  = 2'b01,
        MODE_32  = 2'b10,
        MODE_INV = 2'b11
    } mode_e;

    localparam int K1 = 4,  P1 = 4, N1 = 8;
    localparam int K2 = 11, P2 = 5, N2 = 16;
    localparam int K3 = 26, P3 = 6, N3 = 32;
    localparam int KMAX = K3, PMAX = P3, NMAX = N3;

    // Data column i carries the i-th smallest value of weight >= 2, so the three codes share
    // their low columns; parity columns are the identity, the top row is overall parity.
    localparam logic [P1-1:0][N1-1:0] H1 = {
        8'hFF,
        {4'b1110, 4'b0100},
        {4'b1101, 4'b0010},
        {4'b1011, 4'b0001}
    };

    localparam logic [P2-1:0][N2-1:0] H2 = {
        16'hFFFF,
        {11'h7F0, 5'b01000},
        {11'h78E, 5'b00100},
        {11'h66D, 5'b00010},
        {11'h55B, 5'b00001}
    };

    localparam logic [P3-1:0][N3-1:0] H3 = {
        32'hFFFF_FFFF,
        {15'h7FFF, 11'h000, 6'b010000},
        {15'h7F80, 11'h7F0, 6'b001000},
        {15'h7878, 11'h78E, 6'b000100},
        {15'h6666, 11'h66D, 6'b000010},
        {15'h5555, 11'h55B, 6'b000001}
    };

    // Fills parity positions in place: while row r is evaluated its own parity bit is still 0.
    function automatic logic [NMAX-1:0] ecc_encode(mode_e m, logic [KMAX-1:0] d);
        logic [NMAX-1:0] c;
        c = '0;
        case (m)
            MODE_8: begin
                c[N1-1:P1] = d[K1-1:0];
                for (int r = 0; r < P1-1; r++) c[r] = ^(H1[r] & c[N1-1:0]);
                c[P1-1] = ^c;
            end
            MODE_16: begin
                c[N2-1:P2] = d[K2-1:0];
                for (int r = 0; r < P2-1; r++) c[r] = ^(H2[r] & c[N2-1:0]);
                c[P2-1] = ^c;
            end
            MODE_32: begin
                c[N3-1:P3] = d[K3-1:0];
                for (int r = 0; r < P3-1; r++) c[r] = ^(H3[r] & c[N3-1:0]);
                c[P3-1] = ^c;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ecc_enc_pipe_if.sv
// ecc_enc_pipe_if: input and output valid/ready streams of the SECDED encoder plus its error counter
// Ports: master = source/sink side (drives input beat and out_ready), slave = encoder side.
interface ecc_enc_pipe_if #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    parameter int TAG_WIDTH          = 4
);
    logic                          in_valid;
    logic                          in_ready;
    logic [MAX_INFO_WIDTH-1:0]     data_in;
    logic [1:0]                    mod;
    logic [TAG_WIDTH-1:0]          tag_in;
    logic                          out_valid;
    logic                          out_ready;
    logic [MAX_CODEWORD_WIDTH-1:0] data_out;
    logic [TAG_WIDTH-1:0]          tag_out;
    logic                          out_err;
    logic [7:0]                    err_cnt;

    modport master (
        output in_valid, data_in, mod, tag_in, out_ready,
        input  in_ready, out_valid, data_out, tag_out, out_err, err_cnt
    );

    modport slave (
        input  in_valid, data_in, mod, tag_in, out_ready,
        output in_ready, out_valid, data_out, tag_out, out_err, err_cnt
    );
endinterface

// File: rtl/ecc_parity_rows.sv
// ecc_parity_rows: combinational H-row x data product giving the P-1 row parities of the selected mode
// Ports: mode_i code select, data_i LSB-aligned info bits, rows_o row parities (unused rows read 0).
module ecc_parity_rows
    import ecc_pkg::*;
#(
    parameter int ENABLE_MODE2 = 1
) (
    input  mode_e           mode_i,
    input  logic [KMAX-1:0] data_i,
    output logic [PMAX-2:0] rows_o
);
    logic [PMAX-2:0] r1, r2, r3;

    always_comb begin
        r1 = '0;
        r2 = '0;
        r3 = '0;
        for (int r = 0; r < P1-1; r++) r1[r] = ^(H1[r][N1-1:P1] & data_i[K1-1:0]);
        for (int r = 0; r < P2-1; r++) r2[r] = ^(H2[r][N2-1:P2] & data_i[K2-1:0]);
        for (int r = 0; r < P3-1; r++) r3[r] = ^(H3[r][N3-1:P3] & data_i[K3-1:0]);
        rows_o = mode_i == MODE_8 ? r1 :
                 mode_i == MODE_16 ? r2 :
                 (ENABLE_MODE2 != 0 && mode_i == MODE_32) ? r3 : '0;
    end
endmodule

// File: rtl/ecc_enc_pipe.sv
// ecc_enc_pipe: two-stage pipelined mode-selectable SECDED encoder with valid/ready on both sides
// Ports: clk; rst (async, active-high); bus (slave): input beat in_valid/in_ready/data_in/mod/tag_in,
//        output beat out_valid/out_ready/data_out/tag_out/out_err, err_cnt saturating invalid-mode count.
module ecc_enc_pipe
    import ecc_pkg::*;
#(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_INFO_WIDTH     = 26,
    parameter int TAG_WIDTH          = 4,
    parameter int ENABLE_MODE2       = 1
) (
    input logic           clk,
    input logic           rst,
    ecc_enc_pipe_if.slave bus
);
    logic                 s2_adv, in_ready, accept;
    mode_e                in_mode;
    logic [KMAX-1:0]      in_data;
    logic [PMAX-2:0]      in_rows;
    logic [NMAX-1:0]      cw;
    logic                 s1_valid_q, s1_valid_d;
    mode_e                s1_mode_q, s1_mode_d;
    logic [KMAX-1:0]      s1_data_q, s1_data_d;
    logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;
    logic [PMAX-2:0]      s1_rows_q, s1_rows_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [NMAX-1:0]      s2_cw_q, s2_cw_d;
    logic [TAG_WIDTH-1:0] s2_tag_q, s2_tag_d;
    logic                 s2_err_q, s2_err_d;
    logic [7:0]           err_cnt_q, err_cnt_d;

    assign in_data = KMAX'(bus.data_in);
    // Folding a disabled 32-bit mode into MODE_INV here lets the rest of the pipe treat it as invalid.
    assign in_mode = (bus.mod == 2'b10 && ENABLE_MODE2 == 0) ? MODE_INV : mode_e'(bus.mod);

    ecc_parity_rows #(.ENABLE_MODE2(ENABLE_MODE2)) u_rows (
        .mode_i (in_mode),
        .data_i (in_data),
        .rows_o (in_rows)
    );

    always_comb begin
        s2_adv = !s2_valid_q || bus.out_ready;
        in_ready = !s1_valid_q || s2_adv;
        accept = bus.in_valid && in_ready;
        // Overall parity closes each codeword to even weight; invalid modes pack to zero.
        cw = s1_mode_q == MODE_8 ? {{(NMAX-N1){1'b0}}, s1_data_q[K1-1:0],
                 (^s1_data_q[K1-1:0]) ^ (^s1_rows_q[P1-2:0]), s1_rows_q[P1-2:0]} :
             s1_mode_q == MODE_16 ? {{(NMAX-N2){1'b0}}, s1_data_q[K2-1:0],
                 (^s1_data_q[K2-1:0]) ^ (^s1_rows_q[P2-2:0]), s1_rows_q[P2-2:0]} :
             s1_mode_q == MODE_32 ? {s1_data_q[K3-1:0],
                 (^s1_data_q[K3-1:0]) ^ (^s1_rows_q[P3-2:0]), s1_rows_q[P3-2:0]} : '0;
        s1_valid_d = in_ready ? bus.in_valid : s1_valid_q;
        s1_mode_d = accept ? in_mode : s1_mode_q;
        s1_data_d = accept ? in_data : s1_data_q;
        s1_tag_d = accept ? bus.tag_in : s1_tag_q;
        s1_rows_d = accept ? in_rows : s1_rows_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        s2_cw_d = s2_adv && s1_valid_q ? cw : s2_cw_q;
        s2_tag_d = s2_adv && s1_valid_q ? s1_tag_q : s2_tag_q;
        s2_err_d = s2_adv && s1_valid_q ? s1_mode_q == MODE_INV : s2_err_q;
        err_cnt_d = accept && in_mode == MODE_INV && err_cnt_q != 8'hFF ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= MODE_8;
            s1_data_q  <= '0;
            s1_tag_q   <= '0;
            s1_rows_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_cw_q    <= '0;
            s2_tag_q   <= '0;
            s2_err_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mode_q  <= s1_mode_d;
            s1_data_q  <= s1_data_d;
            s1_tag_q   <= s1_tag_d;
            s1_rows_q  <= s1_rows_d;
            s2_valid_q <= s2_valid_d;
            s2_cw_q    <= s2_cw_d;
            s2_tag_q   <= s2_tag_d;
            s2_err_q   <= s2_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.data_out  = MAX_CODEWORD_WIDTH'(s2_cw_q);
    assign bus.tag_out   = s2_tag_q;
    assign bus.out_err   = s2_err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_ecc_enc_pipe.sv
// tb_ecc_enc_pipe: scoreboard bench for ecc_enc_pipe with directed vectors and a mixed-mode stream
module tb_ecc_enc_pipe;
    import ecc_pkg::*;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    ecc_enc_pipe_if #(.MAX_CODEWORD_WIDTH(32), .MAX_INFO_WIDTH(26), .TAG_WIDTH(4)) bus ();

    ecc_enc_pipe #(
        .MAX_CODEWORD_WIDTH(32),
        .MAX_INFO_WIDTH(26),
        .TAG_WIDTH(4),
        .ENABLE_MODE2(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0]  m;
        logic [31:0] cw;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int errors = 0, checks = 0, n_acc = 0, exp_err = 0, cyc = 0, base = 0, t0 = 0;
    logic [25:0] rd;

    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Nonzero when c violates any H row of the mode, or has bits set above n.
    function automatic logic [5:0] syndrome(logic [1:0] m, logic [31:0] c);
        logic [5:0] s;
        s = '0;
        if (m == 2'b00) begin
            for (int r = 0; r < P1; r++) s[r] = ^(H1[r] & c[N1-1:0]);
            s[5] = |c[31:N1];
        end else if (m == 2'b01) begin
            for (int r = 0; r < P2; r++) s[r] = ^(H2[r] & c[N2-1:0]);
            s[5] = |c[31:N2];
        end else begin
            for (int r = 0; r < P3; r++) s[r] = ^(H3[r] & c);
        end
        return s;
    endfunction

    task automatic send(logic [1:0] m, logic [25:0] d, logic [3:0] t, logic [31:0] cw);
        bus.in_valid = 1;
        bus.mod = m;
        bus.data_in = d;
        bus.tag_in = t;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                q.push_back('{m, cw, t, m == 2'b11});
                n_acc++;
                if (m == 2'b11) exp_err = exp_err < 255 ? exp_err + 1 : 255;
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready low for 100 cycles, expected high");
        bus.in_valid = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("drain_queue_empty", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %h expected no beat", bus.data_out);
            end else begin
                e_mon = q.pop_front();
                chk("data_out", bus.data_out, e_mon.cw);
                chk("tag_out", 32'(bus.tag_out), 32'(e_mon.tag));
                chk("out_err", 32'(bus.out_err), 32'(e_mon.err));
                if (!e_mon.err) begin
                    chk("h_syndrome", 32'(syndrome(e_mon.m, bus.data_out)), 0);
                    chk("even_weight", 32'($countones(bus.data_out) % 2), 0);
                end
            end
        end
    end

    initial begin
        bus.in_valid = 0;
        bus.data_in = 0;
        bus.mod = 0;
        bus.tag_in = 0;
        bus.out_ready = 1;
        #2;
        chk("in_rst_out_valid", 32'(bus.out_valid), 0);
        chk("in_rst_err_cnt", 32'(bus.err_cnt), 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_tag_out", 32'(bus.tag_out), 0);
        chk("rst_out_err", 32'(bus.out_err), 0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 0);
        @(posedge clk);
        #1;

        send(2'b00, 26'h1, 4'h1, 32'h0000_001B);
        bus.in_valid = 0;
        @(negedge clk);
        chk("lat_not_early", 32'(bus.out_valid), 0);
        @(negedge clk);
        chk("lat_valid", 32'(bus.out_valid), 1);
        chk("lat_data", bus.data_out, 32'h0000_001B);
        @(posedge clk);
        #1;

        send(2'b00, 26'hF, 4'h2, 32'h0000_00FF);
        send(2'b10, 26'h0, 4'h3, 32'h0);
        send(2'b01, 26'h1, 4'h4, 32'h0000_0033);
        send(2'b01, 26'h7FF, 4'h5, 32'h0000_FFFF);
        send(2'b10, 26'h1, 4'h6, 32'h0000_0063);
        send(2'b10, 26'h3FF_FFFF, 4'h7, 32'hFFFF_FFFF);
        send(2'b11, 26'h12345, 4'hA, 32'h0);
        bus.in_valid = 0;
        drain();
        chk("err_cnt_one", 32'(bus.err_cnt), 1);

        @(posedge clk);
        #1;
        t0 = cyc;
        for (int i = 0; i < 200; i++) begin
            rd = 26'($urandom);
            send(2'(i % 3), rd, 4'(i), ecc_encode(mode_e'(i % 3), rd));
        end
        chk("throughput_cycles", cyc - t0, 200);
        bus.in_valid = 0;
        drain();

        @(posedge clk);
        #1;
        base = n_acc;
        fork
            begin
                send(2'b00, 26'h1, 4'h1, 32'h0000_001B);
                send(2'b00, 26'hF, 4'h2, 32'h0000_00FF);
                send(2'b01, 26'h1, 4'h3, 32'h0000_0033);
                send(2'b10, 26'h1, 4'h4, 32'h0000_0063);
                bus.in_valid = 0;
            end
            begin
                bus.out_ready = 0;
                repeat (3) @(negedge clk);
                chk("bp_hold_data_early", bus.data_out, 32'h0000_001B);
                repeat (2) @(negedge clk);
                chk("bp_in_ready_low", 32'(bus.in_ready), 0);
                chk("bp_absorbed", n_acc - base, 2);
                chk("bp_hold_valid", 32'(bus.out_valid), 1);
                chk("bp_hold_data", bus.data_out, 32'h0000_001B);
                chk("bp_hold_tag", 32'(bus.tag_out), 1);
                @(posedge clk);
                #1 bus.out_ready = 1;
            end
        join
        drain();

        @(posedge clk);
        #1;
        for (int i = 0; i < 300; i++) send(2'b11, 26'(i), 4'(i), 32'h0);
        bus.in_valid = 0;
        drain();
        chk("err_cnt_saturated", 32'(bus.err_cnt), 255);

        @(posedge clk);
        #1;
        send(2'b00, 26'h3, 4'h1, 32'h0000_0036);
        send(2'b00, 26'h2, 4'h2, 32'h0);
        #1;
        chk("rst_pre_valid", 32'(bus.out_valid), 1);
        rst = 1;
        bus.in_valid = 0;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 0);
        chk("async_rst_err_cnt", 32'(bus.err_cnt), 0);
        chk("async_rst_data_out", bus.data_out, 0);
        q.delete();
        exp_err = 0;
        repeat (2) @(posedge clk);
        #3 rst = 0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);
        chk("post_rst_out_valid", 32'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        send(2'b00, 26'h1, 4'h9, 32'h0000_001B);
        bus.in_valid = 0;
        drain();
        chk("post_rst_err_cnt", 32'(bus.err_cnt), 32'(exp_err));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
